// File: rtl/cv32e40p_tmr_div_voter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_tmr_div_voter
// Purpose  : Bitwise 2-of-3 voter for the triplicated divider result lanes,
//            with per-lane mismatch counters, sticky fault detection after a
//            run of consecutive disagreements, and a four-phase alert
//            handshake toward the SoC safety controller.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_div_voter #(
  parameter int WIDTH        = 33,
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     lane0_i,
  input  logic [WIDTH-1:0]     lane1_i,
  input  logic [WIDTH-1:0]     lane2_i,
  input  logic                 clear_i,
  output logic [WIDTH-1:0]     voted_o,
  output logic                 voted_valid_o,
  output logic [2:0]           mismatch_o,
  output logic                 uncorrectable_o,
  output logic [2:0]           fault_lane_o,
  output logic [ERR_CNT_W-1:0] err_cnt0_o,
  output logic [ERR_CNT_W-1:0] err_cnt1_o,
  output logic [ERR_CNT_W-1:0] err_cnt2_o,
  output logic                 alert_req_o,
  input  logic                 alert_ack_i
);

  // Run counters are 4 bits wide, so the threshold is held in the same width.
  localparam logic [3:0] RUN_THRESH = 4'(FAULT_THRESH);

  typedef enum logic [1:0] {
    ALERT_IDLE = 2'd0,
    ALERT_REQ  = 2'd1,
    ALERT_HOLD = 2'd2
  } alert_state_e;

  logic [WIDTH-1:0] maj;
  logic [2:0]       mism;
  logic             unc;

  logic [WIDTH-1:0] voted_q;
  logic             valid_q;
  logic [2:0]       mismatch_q;
  logic             unc_q;
  logic [2:0]       fault_prev_q;

  alert_state_e     alert_state_q;
  logic             pending_q;
  logic             alert_req_q;
  logic             alert_event;

  assign maj = (lane0_i & lane1_i) | (lane1_i & lane2_i) | (lane0_i & lane2_i);

  // Per-lane comparison, error counting and consecutive-run fault detection.
  for (genvar k = 0; k < 3; k++) begin : g_lane
    logic [WIDTH-1:0]     lane;
    logic                 lane_mism;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [3:0]           run_q;
    logic                 fault_q;

    assign lane      = (k == 0) ? lane0_i : ((k == 1) ? lane1_i : lane2_i);
    assign lane_mism = (lane != maj);

    // Clear wins over any same-cycle increment; disabled cycles hold the run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q   <= '0;
        run_q   <= '0;
        fault_q <= 1'b0;
      end else if (clear_i) begin
        cnt_q   <= '0;
        run_q   <= '0;
        fault_q <= 1'b0;
      end else if (en_i) begin
        if (lane_mism) begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + ERR_CNT_W'(1);
          end
          if (run_q < RUN_THRESH) begin
            run_q <= run_q + 4'd1;
          end
          // This sample is the FAULT_THRESH-th consecutive mismatch (or later).
          if (run_q >= RUN_THRESH - 4'd1) begin
            fault_q <= 1'b1;
          end
        end else begin
          run_q <= '0;
        end
      end
    end
  end

  assign mism = {g_lane[2].lane_mism, g_lane[1].lane_mism, g_lane[0].lane_mism};
  assign unc  = &mism;

  // Registered vote and per-sample status; vote holds while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      voted_q      <= '0;
      valid_q      <= 1'b0;
      mismatch_q   <= '0;
      unc_q        <= 1'b0;
      fault_prev_q <= '0;
    end else begin
      valid_q      <= en_i;
      fault_prev_q <= fault_lane_o;
      if (en_i) begin
        voted_q    <= maj;
        mismatch_q <= mism;
        unc_q      <= unc;
      end else begin
        mismatch_q <= '0;
        unc_q      <= 1'b0;
      end
    end
  end

  // A newly faulted lane or an uncorrectable sample both request an alert.
  assign alert_event = (|(fault_lane_o & ~fault_prev_q)) | unc_q;

  // Four-phase alert handshake; events during a handshake are coalesced
  // into a single pending bit and replayed once the handshake completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alert_state_q <= ALERT_IDLE;
      pending_q     <= 1'b0;
      alert_req_q   <= 1'b0;
    end else if (clear_i) begin
      alert_state_q <= ALERT_IDLE;
      pending_q     <= 1'b0;
      alert_req_q   <= 1'b0;
    end else begin
      case (alert_state_q)
        ALERT_IDLE: begin
          if (alert_event || pending_q) begin
            alert_state_q <= ALERT_REQ;
            alert_req_q   <= 1'b1;
            pending_q     <= 1'b0;
          end
        end
        ALERT_REQ: begin
          if (alert_event) begin
            pending_q <= 1'b1;
          end
          if (alert_ack_i) begin
            alert_state_q <= ALERT_HOLD;
            alert_req_q   <= 1'b0;
          end
        end
        ALERT_HOLD: begin
          if (alert_event) begin
            pending_q <= 1'b1;
          end
          if (!alert_ack_i) begin
            alert_state_q <= ALERT_IDLE;
          end
        end
        default: begin
          alert_state_q <= ALERT_IDLE;
          alert_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign voted_o         = voted_q;
  assign voted_valid_o   = valid_q;
  assign mismatch_o      = mismatch_q;
  assign uncorrectable_o = unc_q;
  assign fault_lane_o    = {g_lane[2].fault_q, g_lane[1].fault_q, g_lane[0].fault_q};
  assign err_cnt0_o      = g_lane[0].cnt_q;
  assign err_cnt1_o      = g_lane[1].cnt_q;
  assign err_cnt2_o      = g_lane[2].cnt_q;
  assign alert_req_o     = alert_req_q;

endmodule
`default_nettype wire
